// File: rtl/cordic_pipe.sv
// Pipelined CORDIC with rotation or vectoring selected per sample and valid/ready flow control.
// Define CORDIC_GAIN_COMP_EN to add a registered unity-gain stage (one cycle of extra latency).
module cordic_pipe #(
  parameter int BIT_WIDTH = 16,
  parameter int STAGES    = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic signed [BIT_WIDTH-1:0] in_x,
  input  logic signed [BIT_WIDTH-1:0] in_y,
  input  logic signed [BIT_WIDTH-1:0] in_angle,
  input  logic        [TAG_WIDTH-1:0] in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] out_x,
  output logic signed [BIT_WIDTH-1:0] out_y,
  output logic signed [BIT_WIDTH-1:0] out_angle,
  output logic        [TAG_WIDTH-1:0] out_tag
);

  localparam int  XW = BIT_WIDTH + 2;
  localparam real PI = 3.14159265358979323846;
  localparam logic        [BIT_WIDTH-1:0] HALF_TURN = BIT_WIDTH'(1) << (BIT_WIDTH - 1);
  localparam logic signed [BIT_WIDTH-1:0] QUARTER   = BIT_WIDTH'(1) << (BIT_WIDTH - 2);
  localparam logic signed [XW-1:0]        SAT_HI    = XW'((1 << (BIT_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0]        SAT_LO    = ~SAT_HI;

  // atan(2^-s) in binary-angle units, packed one entry per micro-rotation.
  function automatic logic [STAGES*BIT_WIDTH-1:0] atan_table();
    logic [STAGES*BIT_WIDTH-1:0] t;
    real ang;
    t = '0;
    for (int s = 0; s < STAGES; s++) begin
      ang = $atan(1.0 / (2.0 ** s)) / (2.0 * PI) * (2.0 ** BIT_WIDTH);
      t[s*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'($rtoi(ang + 0.5));
    end
    return t;
  endfunction

  localparam logic [STAGES*BIT_WIDTH-1:0] ATAN_TAB = atan_table();

  function automatic logic signed [BIT_WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[BIT_WIDTH-1:0];
    else if (v < SAT_LO) return SAT_LO[BIT_WIDTH-1:0];
    else                 return v[BIT_WIDTH-1:0];
  endfunction

  typedef struct packed {
    logic                 mode;
    logic [TAG_WIDTH-1:0] tag;
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic [BIT_WIDTH-1:0] z;
  } data_t;

  logic                 adv;
  logic [STAGES:0]      vld;
  data_t                dat [0:STAGES];
  data_t                nxt [1:STAGES];
  data_t                pre;
  data_t                fin;
  logic                 fin_vld;
  logic                 dir;
  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;

  // Whole pipeline moves as one; a stalled output register freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Pre-rotation folds the input into the right half-plane so the micro-rotations converge.
  // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
  // only clocked blocks use '<='.
  always_comb begin
    pre.mode = in_mode;
    pre.tag  = in_tag;
    pre.x    = XW'(in_x);
    pre.y    = XW'(in_y);
    pre.z    = in_angle;
    if (in_mode ? (in_x < 0) : (in_angle > QUARTER || in_angle < -QUARTER)) begin
      pre.x = -XW'(in_x);
      pre.y = -XW'(in_y);
      pre.z = in_angle + HALF_TURN;
    end
  end

  // NOTE: every variable gets a value before any branch so no latch is inferred.
  always_comb begin
    dir = 1'b0;
    xs  = '0;
    ys  = '0;
    for (int i = 1; i <= STAGES; i++) begin
      nxt[i] = dat[i-1];
      xs     = $signed(dat[i-1].x) >>> (i - 1);
      ys     = $signed(dat[i-1].y) >>> (i - 1);
      dir    = dat[i-1].mode ? ($signed(dat[i-1].y) <= 0) : !dat[i-1].z[BIT_WIDTH-1];
      if (dir) begin
        nxt[i].x = dat[i-1].x - ys;
        nxt[i].y = dat[i-1].y + xs;
        nxt[i].z = dat[i-1].z - ATAN_TAB[(i-1)*BIT_WIDTH +: BIT_WIDTH];
      end else begin
        nxt[i].x = dat[i-1].x + ys;
        nxt[i].y = dat[i-1].y - xs;
        nxt[i].z = dat[i-1].z + ATAN_TAB[(i-1)*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  vld <= '0;
    else if (adv)  vld <= {vld[STAGES-1:0], in_valid};
  end

  // NOTE: stage data is left unreset; the valid flags alone decide whether it means anything.
  always_ff @(posedge clk) begin
    if (adv) begin
      dat[0] <= pre;
      for (int i = 1; i <= STAGES; i++) dat[i] <= nxt[i];
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic signed [BIT_WIDTH:0] gain_code();
    real k;
    k = 1.0;
    for (int s = 0; s < STAGES; s++) k = k * $sqrt(1.0 + 1.0 / (2.0 ** (2 * s)));
    return (BIT_WIDTH+1)'($rtoi((2.0 ** (BIT_WIDTH - 1)) / k + 0.5));
  endfunction

  localparam logic signed [BIT_WIDTH:0] GAIN = gain_code();

  logic signed [XW+BIT_WIDTH:0] px;
  logic signed [XW+BIT_WIDTH:0] py;
  logic                         gvld;
  data_t                        gdat;
  data_t                        gnxt;

  always_comb begin
    px     = $signed(dat[STAGES].x) * GAIN;
    py     = $signed(dat[STAGES].y) * GAIN;
    gnxt   = dat[STAGES];
    gnxt.x = XW'(px >>> (BIT_WIDTH - 1));
    gnxt.y = XW'(py >>> (BIT_WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gvld <= 1'b0;
    else if (adv) gvld <= vld[STAGES];
  end

  always_ff @(posedge clk) begin
    if (adv) gdat <= gnxt;
  end

  assign fin_vld = gvld;
  assign fin     = gdat;
`else
  assign fin_vld = vld[STAGES];
  assign fin     = dat[STAGES];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_angle <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        out_x     <= sat($signed(fin.x));
        out_y     <= sat($signed(fin.y));
        out_angle <= fin.z;
        out_tag   <= fin.tag;
      end
    end
  end

endmodule
